// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state encoding and instruction-width helpers
// shared by param_cpu_core and cpu_alu.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_MOV  = 4'h8,
    OP_LDA  = 4'h9,
    OP_LDB  = 4'hA,
    OP_OUT  = 4'hB,
    OP_JNZ  = 4'hC,
    OP_NOP0 = 4'hD,
    OP_NOP1 = 4'hE,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  function automatic int rsel_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

  function automatic int instr_w(input int num_regs);
    return 4 + 2 * $clog2(num_regs);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU; ports op/a/b/sw_a/sw_b/cin in, res/cout/wr out.
// MUL/DIV exist only when CPU_MULDIV_EN is defined, else opcodes 2/3 are NOPs.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] sw_a,
  input  logic [DATA_W-1:0] sw_b,
  input  logic              cin,
  output logic [DATA_W-1:0] res,
  output logic              cout,
  output logic              wr
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

`ifdef CPU_MULDIV_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  // Ops that do not touch the flag pass cin straight through.
  always_comb begin
    res  = '0;
    cout = cin;
    wr   = 1'b0;
    unique case (op)
      OP_ADD: begin
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
        wr   = 1'b1;
      end
      OP_SUB: begin
        res  = dif[DATA_W-1:0];
        cout = dif[DATA_W];
        wr   = 1'b1;
      end
`ifdef CPU_MULDIV_EN
      OP_MUL: begin
        res  = prod[DATA_W-1:0];
        cout = |prod[2*DATA_W-1:DATA_W];
        wr   = 1'b1;
      end
      OP_DIV: begin
        wr = 1'b1;
        if (b == '0) begin
          res  = '1;
          cout = 1'b1;
        end else begin
          res  = a / b;
          cout = 1'b0;
        end
      end
`endif
      OP_SHL: begin
        {cout, res} = {a, 1'b0};
        wr = 1'b1;
      end
      OP_SHR: begin
        {res, cout} = {1'b0, a};
        wr = 1'b1;
      end
      OP_AND: begin
        res  = a & b;
        cout = 1'b0;
        wr   = 1'b1;
      end
      OP_OR: begin
        res  = a | b;
        cout = 1'b0;
        wr   = 1'b1;
      end
      OP_MOV: begin
        res = b;
        wr  = 1'b1;
      end
      OP_LDA: begin
        res = sw_a;
        wr  = 1'b1;
      end
      OP_LDB: begin
        res = sw_b;
        wr  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_cpu_core.sv
// param_cpu_core: 4-cycle multi-cycle CPU (FETCH/DECODE/EXEC/WB + HALT).
// clk/reset_n, run/step, sw_a/sw_b, imem_*, instr/out_reg/carry/state/halted; CPU_MULDIV_EN.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  parameter  int PC_W     = 8,
  localparam int RSEL_W   = rsel_w(NUM_REGS),
  localparam int INSTR_W  = instr_w(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               step,
  input  logic [DATA_W-1:0]  sw_a,
  input  logic [DATA_W-1:0]  sw_b,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  out_reg,
  output logic               carry,
  output logic [2:0]         state,
  output logic               halted
);

  state_e            st;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] res_q;
  logic              cout_q;
  logic              wr_q;

  op_e               op;
  logic [RSEL_W-1:0] rd;
  logic [RSEL_W-1:0] rs;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;
  logic              alu_wr;
  logic [PC_W-1:0]   jtgt;
  logic              go;

  assign op        = op_e'(instr[INSTR_W-1 -: 4]);
  assign rd        = instr[2*RSEL_W-1 -: RSEL_W];
  assign rs        = instr[RSEL_W-1:0];
  assign go        = run | step;
  assign jtgt      = PC_W'(opa);
  assign imem_addr = pc;
  assign state     = st;

  cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op  (op),
    .a   (opa),
    .b   (opb),
    .sw_a(sw_a),
    .sw_b(sw_b),
    .cin (carry),
    .res (alu_res),
    .cout(alu_cout),
    .wr  (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st      <= S_FETCH;
      pc      <= '0;
      instr   <= '0;
      opa     <= '0;
      opb     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      wr_q    <= 1'b0;
      out_reg <= '0;
      carry   <= 1'b0;
      halted  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      unique case (st)
        S_FETCH: begin
          if (go) begin
            instr <= imem_data;
            pc    <= pc + PC_W'(1);
            st    <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa <= regs[rd];
          opb <= regs[rs];
          st  <= S_EXEC;
        end
        S_EXEC: begin
          res_q  <= alu_res;
          cout_q <= alu_cout;
          wr_q   <= alu_wr;
          st     <= S_WB;
        end
        S_WB: begin
          if (wr_q) regs[rd] <= res_q;
          carry <= cout_q;
          if (op == OP_OUT) out_reg <= opb;
          if (op == OP_JNZ && opb != '0) pc <= jtgt;
          if (op == OP_HALT) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else begin
            st <= S_FETCH;
          end
        end
        S_HALT: ;
        default: st <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// tb_param_cpu_core: ISA-level reference model feeds a retirement scoreboard;
// directed programs plus random ROMs.
module tb_param_cpu_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] sw_a = 8'h00;
  logic [7:0] sw_b = 8'h00;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic [7:0] out_reg;
  logic       carry;
  logic [2:0] state;
  logic       halted;

  logic [7:0] rom [256];
  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  param_cpu_core #(
    .DATA_W  (8),
    .NUM_REGS(4),
    .PC_W    (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .step     (step),
    .sw_a     (sw_a),
    .sw_b     (sw_b),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instr    (instr),
    .out_reg  (out_reg),
    .carry    (carry),
    .state    (state),
    .halted   (halted)
  );

  typedef struct {
    int pc;
    int outv;
    int c;
    int h;
  } rec_t;

  rec_t       sb[$];
  rec_t       e;
  int         tests = 0;
  int         fails = 0;
  int         retired = 0;
  int         m_pc;
  int         m_halt;
  logic [2:0] prev_st = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Retirement = leaving WB; compare architectural state with the model.
  always @(posedge clk) begin
    #1;
    if (reset_n && prev_st == 3'd3 && state != 3'd3) begin
      retired++;
      if (sb.size() == 0) begin
        chk("extra_retire", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ret_pc", int'(imem_addr), e.pc);
        chk("ret_out", int'(out_reg), e.outv);
        chk("ret_carry", int'(carry), e.c);
        chk("ret_state", int'(state), e.h != 0 ? 4 : 0);
      end
    end
    prev_st = state;
  end

  // Instruction-set model: runs up to max_n instructions from pc 0.
  task automatic model_run(input int max_n, output int n);
    int r[4];
    int pc, c, o, h, op, rd, rs, a, b, res;
    bit wr;
    for (int i = 0; i < 4; i++) r[i] = 0;
    pc = 0; c = 0; o = 0; h = 0; n = 0;
    while (n < max_n && h == 0) begin
      op = int'(rom[pc][7:4]);
      rd = int'(rom[pc][3:2]);
      rs = int'(rom[pc][1:0]);
      pc = (pc + 1) % 256;
      a = r[rd];
      b = r[rs];
      wr = 1;
      res = 0;
      case (op)
        0: begin res = a + b; c = (res > 255) ? 1 : 0; end
        1: begin res = a - b; c = (a < b) ? 1 : 0; end
`ifdef CPU_MULDIV_EN
        2: begin res = a * b; c = (res > 255) ? 1 : 0; end
        3: begin
          if (b == 0) begin res = 255; c = 1; end
          else begin res = a / b; c = 0; end
        end
`endif
        4: begin res = a * 2; c = (a >= 128) ? 1 : 0; end
        5: begin res = a / 2; c = a % 2; end
        6: begin res = a & b; c = 0; end
        7: begin res = a | b; c = 0; end
        8: res = b;
        9: res = int'(sw_a);
        10: res = int'(sw_b);
        11: begin wr = 0; o = b; end
        12: begin wr = 0; if (b != 0) pc = a; end
        15: begin wr = 0; h = 1; end
        default: wr = 0;
      endcase
      if (wr) r[rd] = res & 255;
      n++;
      sb.push_back(rec_t'{pc, o, c, h});
    end
    m_pc = pc;
    m_halt = h;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_pc", int'(imem_addr), 0);
    chk("rst_out", int'(out_reg), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_instr", int'(instr), 0);
  endtask

  task automatic finish_run(input int n, input int base);
    int k = 0;
    while (retired - base < n && k < 4 * n + 40) begin
      @(negedge clk);
      k++;
    end
    chk("retire_count", retired - base, n);
    run = 1'b0;
    repeat (8) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("end_pc", int'(imem_addr), m_pc);
    chk("end_state", int'(state), m_halt != 0 ? 4 : 0);
    chk("end_halted", int'(halted), m_halt);
  endtask

  task automatic run_prog(input int max_n);
    int n, base;
    do_reset();
    model_run(max_n, n);
    base = retired;
    reset_n = 1'b1;
    run = 1'b1;
    finish_run(n, base);
  endtask

  initial begin
    int n, base, k;
    fill(8'hF0);
    do_reset();

    // LDA r0, LDB r1, ADD r0,r1, OUT r0, HALT with cycle timing
    rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h01;
    rom[3] = 8'hB0; rom[4] = 8'hF0;
    sw_a = 8'h05; sw_b = 8'h03;
    do_reset();
    model_run(10, n);
    base = retired;
    reset_n = 1'b1;
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 15) chk("cyc15_out", int'(out_reg), 0);
      if (c == 16) chk("cyc16_out", int'(out_reg), 8);
      if (c == 19) chk("cyc19_halted", int'(halted), 0);
      if (c == 20) chk("cyc20_halted", int'(halted), 1);
    end
    finish_run(n, base);

    // ADD overflow
    sw_a = 8'hF0; sw_b = 8'h20;
    run_prog(10);

    // DIV by zero
    fill(8'hF0);
    rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h31; rom[3] = 8'hB0;
    sw_a = 8'hF0; sw_b = 8'h00;
    run_prog(10);

    // JNZ taken: loops back to 0
    fill(8'hF0);
    rom[0] = 8'h98; rom[1] = 8'hAC; rom[2] = 8'hCB; rom[3] = 8'hB3;
    sw_a = 8'h00; sw_b = 8'h01;
    run_prog(7);
    // JNZ not taken
    sw_b = 8'h00;
    run_prog(10);

    // Single step with run=0; second strobe lands in DECODE
    fill(8'hD0);
    do_reset();
    model_run(1, n);
    base = retired;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pc", int'(imem_addr), 0);
    chk("idle_state", int'(state), 0);
    step = 1'b1;
    @(negedge clk);
    chk("step_decode", int'(state), 1);
    @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
    chk("step_pc", int'(imem_addr), 1);
    chk("step_state", int'(state), 0);
    chk("step_retired", retired - base, 1);
    chk("step_sb", sb.size(), 0);

    // Reset during EXEC of ADD must leave registers cleared
    fill(8'hF0);
    rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h01; rom[3] = 8'hB0;
    sw_a = 8'h05; sw_b = 8'h03;
    do_reset();
    model_run(10, n);
    base = retired;
    reset_n = 1'b1;
    run = 1'b1;
    k = 0;
    while (!(retired - base == 2 && state == 3'd2) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach", (retired - base == 2 && state == 3'd2) ? 1 : 0, 1);
    fill(8'hF0);
    rom[0] = 8'hB0; rom[1] = 8'hB1; rom[2] = 8'h01; rom[3] = 8'hB0;
    sw_a = 8'h00; sw_b = 8'h00;
    run_prog(10);

    // Random ROMs
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      sw_a = 8'($urandom);
      sw_b = 8'($urandom);
      run_prog(30);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_cpu_core.md
PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register, ALU and switch-operand width.
REQ-002 SHALL have parameter NUM_REGS, default 4: register-file depth; power of 2, at least 2; RSEL_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter PC_W, default 8: program-counter and instruction-address width.
REQ-004 SHALL derive INSTR_W = 4 + 2*RSEL_W; instruction format is {op[3:0], rd[RSEL_W-1:0], rs[RSEL_W-1:0]}.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  free-run enable.
- step  in  1  one-cycle single-step strobe.
- sw_a  in  DATA_W  operand for LDA.
- sw_b  in  DATA_W  operand for LDB.
- imem_addr  out  PC_W  equals pc.
- imem_data  in  INSTR_W  combinational ROM data for imem_addr.
- instr  out  INSTR_W  instruction register.
- out_reg  out  DATA_W  output register.
- carry  out  1  carry/borrow flag.
- state  out  3  FSM state code.
- halted  out  1  high in HALT.

Function
REQ-006 SHALL implement FSM FETCH(0) -> DECODE(1) -> EXEC(2) -> WB(3) -> FETCH, plus HALT(4).
REQ-007 In FETCH, when go = run | step: SHALL load instr <= imem_data, set pc <= pc+1 (wrapping from 2^PC_W-1 to 0) and go to DECODE; otherwise SHALL hold all state.
REQ-008 DECODE, EXEC and WB SHALL each take exactly one cycle regardless of run/step, so one instruction costs 4 cycles when run=1.
REQ-009 step SHALL be ignored outside FETCH; run and step both high SHALL behave as run.
REQ-010 DECODE SHALL latch opa <= R[rd] and opb <= R[rs]; EXEC SHALL latch the ALU result and next carry; WB SHALL commit the result.
REQ-011 Opcodes 0-7 (ADD, SUB, MUL, DIV, SHL, SHR, AND, OR) SHALL write R[rd] <= R[rd] op R[rs] in WB.
REQ-012 ALU carry rules, all results truncated to DATA_W:
- ADD: carry = carry-out.
- SUB: carry = borrow (opa < opb).
- MUL: result = low half; carry = (high half != 0).
- DIV: result = quotient; carry = 0.
- SHL/SHR: shift by 1; carry = bit shifted out.
- AND/OR: carry = 0.
REQ-013 DIV with opb = 0 SHALL yield an all-ones result with carry = 1.
REQ-014 Opcode 8 MOV SHALL set R[rd] <= R[rs]; opcode 9 LDA SHALL set R[rd] <= sw_a; opcode A LDB SHALL set R[rd] <= sw_b. sw_a/sw_b are sampled in EXEC. None of 8/9/A changes carry.
REQ-015 Opcode B OUT SHALL set out_reg <= R[rs] in WB.
REQ-016 Opcode C JNZ SHALL, when R[rs] != 0, set pc <= R[rd][PC_W-1:0] in WB (zero-extended if DATA_W < PC_W); otherwise pc is unchanged.
REQ-017 Opcode D and opcode E SHALL be NOPs.
REQ-018 Opcode F HALT SHALL enter HALT at the end of WB; HALT SHALL hold all state, with halted=1, until reset.
REQ-019 A register write in WB SHALL be visible to the next instruction's DECODE.

Reset
REQ-020 reset_n=0 at a clock edge SHALL set: pc=0, instr=0, all R[i]=0, opa=opb=0, out_reg=0, carry=0, state=FETCH, halted=0.
REQ-021 Reset SHALL take priority over every state, including mid-instruction; the aborted instruction SHALL commit nothing.

Configuration
REQ-022 With macro CPU_MULDIV_EN defined: MUL and DIV SHALL behave per REQ-012/013. Without it: opcodes 2 and 3 SHALL act as NOPs (no register or carry write) and no multiplier/divider SHALL be synthesised.

Structure
REQ-023 Shared package cpu_pkg SHALL hold the opcode enumeration, the FSM state encoding and the INSTR_W/RSEL_W derivation functions.
REQ-024 The ALU SHALL be a combinational sub-module cpu_alu(DATA_W); the register file and FSM SHALL stay in param_cpu_core.

Verification (DATA_W=8, NUM_REGS=4, PC_W=8)
REQ-025 Reset: hold reset_n=0 for 2 cycles -> pc=0, out_reg=0x00, state=0, halted=0.
REQ-026 Program run: LDA r0 (sw_a=0x05), LDB r1 (sw_b=0x03), ADD r0,r1, OUT r0, HALT with run=1 -> out_reg=0x08 at cycle 16; halted=1 from cycle 20.
REQ-027 Overflow: ADD with r0=0xF0, r1=0x20 -> r0=0x10, carry=1. Divide by zero: DIV with r1=0 -> 0xFF, carry=1.
REQ-028 Single step: with run=0, one step pulse -> pc 0->1, state returns to FETCH and holds; a step pulse issued during DECODE -> ignored.
REQ-029 Loop: JNZ with r2=0x00 (target) and r3=0x01 (condition) -> pc=0x00 after WB; with r3=0x00 -> pc advances normally.
REQ-030 Abort: reset_n=0 during EXEC of ADD -> all registers read 0 and no write occurs.
